// File: rtl/pal_cfg_loader.sv
// -----------------------------------------------------------------------------
// pal_cfg_loader
//
// Loads the PAL fabric configuration chain from a word-wide valid/ready stream.
// Each accepted word is shifted out MSB-first, one bit per cycle, onto the PAL
// serial config input (pal_cfg, qualified by pal_shift). Once CFG_BITS bits have
// been shifted, pal_en is held high for APPLY_CYCLES cycles and the sticky done
// flag is raised. If the source stalls for TIMEOUT idle cycles, the load is
// abandoned with the sticky err flag set.
//
// Ports
//   clk        clock, rising edge
//   res_n      asynchronous active-low reset
//   start      pulse: begin a load (ignored while busy)
//   abort      pulse: cancel, return to IDLE, clear flags (beats start)
//   s_data     config word, MSB shifted first
//   s_valid    s_data valid
//   s_ready    loader takes s_data this cycle
//   pal_cfg    serial config bit to the PAL chain
//   pal_shift  pal_cfg valid, PAL chain shifts this cycle
//   pal_en     PAL apply enable
//   busy       load or apply in progress
//   done       sticky: last load completed
//   err        sticky: last load timed out
//   bit_cnt    bits shifted so far in the current load
// -----------------------------------------------------------------------------
module pal_cfg_loader #(
    parameter int CFG_BITS     = 736,
    parameter int WORD_W       = 8,
    parameter int APPLY_CYCLES = 2,
    parameter int TIMEOUT      = 1023
) (
    input  logic                          clk,
    input  logic                          res_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [WORD_W-1:0]             s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          pal_cfg,
    output logic                          pal_shift,
    output logic                          pal_en,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [$clog2(CFG_BITS+1)-1:0] bit_cnt
);

    localparam int CW = $clog2(CFG_BITS + 1);
    localparam int BW = $clog2(WORD_W + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int AW = (APPLY_CYCLES > 1) ? $clog2(APPLY_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_APPLY,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t            state_reg, state_next;
    logic [WORD_W-1:0] shreg_reg, shreg_next;
    logic [BW-1:0]     bits_left_reg, bits_left_next;
    logic [CW-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [TW-1:0]     tmo_reg, tmo_next;
    logic [AW-1:0]     apply_reg, apply_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;

    logic shifting;
    logic words_needed;
    logic accept;
    logic last_bit;
    logic idle_cycle;
    logic tmo_hit;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_reg     <= ST_IDLE;
            shreg_reg     <= '0;
            bits_left_reg <= '0;
            bit_cnt_reg   <= '0;
            tmo_reg       <= '0;
            apply_reg     <= '0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shreg_reg     <= shreg_next;
            bits_left_reg <= bits_left_next;
            bit_cnt_reg   <= bit_cnt_next;
            tmo_reg       <= tmo_next;
            apply_reg     <= apply_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        shreg_next     = shreg_reg;
        bits_left_next = bits_left_reg;
        bit_cnt_next   = bit_cnt_reg;
        tmo_next       = tmo_reg;
        apply_next     = apply_reg;
        done_next      = done_reg;
        err_next       = err_reg;

        shifting     = (state_reg == ST_LOAD) && (bits_left_reg != '0);
        // Only request another word if the bits already held do not finish the chain.
        words_needed = (int'(bit_cnt_reg) + int'(bits_left_reg)) < CFG_BITS;
        // Ready on the final bit of a word too, so the next word lands without a bubble.
        s_ready      = (state_reg == ST_LOAD) && (bits_left_reg <= BW'(1)) && words_needed;
        accept       = s_ready && s_valid;
        last_bit     = shifting && (bit_cnt_reg == CW'(CFG_BITS - 1));
        idle_cycle   = (state_reg == ST_LOAD) && (bits_left_reg == '0) && !s_valid;
        tmo_hit      = 1'b0;
        if (TIMEOUT > 0) begin
            tmo_hit = idle_cycle && (tmo_reg == TW'(TIMEOUT - 1));
        end

        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_next     = ST_LOAD;
                    done_next      = 1'b0;
                    err_next       = 1'b0;
                    bit_cnt_next   = '0;
                    bits_left_next = '0;
                    shreg_next     = '0;
                    tmo_next       = '0;
                end
            end

            ST_LOAD: begin
                if (shifting) begin
                    shreg_next     = shreg_reg << 1;
                    bits_left_next = bits_left_reg - BW'(1);
                    if (bit_cnt_reg != CW'(CFG_BITS)) begin
                        bit_cnt_next = bit_cnt_reg + CW'(1);
                    end
                end
                if (accept) begin
                    shreg_next     = s_data;
                    bits_left_next = BW'(WORD_W);
                    tmo_next       = '0;
                end else if (idle_cycle && (TIMEOUT > 0)) begin
                    tmo_next = tmo_reg + TW'(1);
                end
                if (last_bit) begin
                    // Chain is full: any unshifted low bits of the final word are dropped.
                    bits_left_next = '0;
                    shreg_next     = '0;
                    apply_next     = '0;
                    state_next     = ST_APPLY;
                end else if (tmo_hit) begin
                    state_next = ST_ERR;
                    err_next   = 1'b1;
                end
            end

            ST_APPLY: begin
                if (apply_reg == AW'(APPLY_CYCLES - 1)) begin
                    state_next = ST_DONE;
                    done_next  = 1'b1;
                end else begin
                    apply_next = apply_reg + AW'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Abort overrides everything, including a start in the same cycle.
        if (abort) begin
            state_next     = ST_IDLE;
            done_next      = 1'b0;
            err_next       = 1'b0;
            bit_cnt_next   = '0;
            bits_left_next = '0;
            shreg_next     = '0;
            tmo_next       = '0;
            apply_next     = '0;
        end

        pal_shift = shifting;
        pal_cfg   = shifting & shreg_reg[WORD_W-1];
        // Decoded straight from the state register so reset drops it without a clock.
        pal_en    = (state_reg == ST_APPLY);
        busy      = (state_reg == ST_LOAD) || (state_reg == ST_APPLY);
        done      = done_reg;
        err       = err_reg;
        bit_cnt   = bit_cnt_reg;
    end

endmodule

// File: tb/tb_pal_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_pal_cfg_loader
//
// Directed bench for pal_cfg_loader. Three instances:
//   u_dut_a : default parameters (736-bit chain)
//   u_dut_b : 20-bit chain, exercises truncation of the final word
//   u_dut_c : 736-bit chain with TIMEOUT=16, exercises the stall timeout
// B and C share data/valid/abort but have separate start pulses.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pal_cfg_loader;

    localparam int CFG_A = 736;
    localparam int NW_A  = 92;

    logic clk   = 1'b0;
    logic res_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // ---------------- DUT A ----------------
    logic       a_start   = 1'b0;
    logic       a_abort   = 1'b0;
    logic       a_s_valid = 1'b0;
    logic [7:0] a_s_data  = 8'h00;
    logic       a_s_ready, a_pal_cfg, a_pal_shift, a_pal_en, a_busy, a_done, a_err;
    logic [9:0] a_bit_cnt;

    pal_cfg_loader #(.CFG_BITS(736), .WORD_W(8), .APPLY_CYCLES(2), .TIMEOUT(1023)) u_dut_a (
        .clk(clk), .res_n(res_n), .start(a_start), .abort(a_abort),
        .s_data(a_s_data), .s_valid(a_s_valid), .s_ready(a_s_ready),
        .pal_cfg(a_pal_cfg), .pal_shift(a_pal_shift), .pal_en(a_pal_en),
        .busy(a_busy), .done(a_done), .err(a_err), .bit_cnt(a_bit_cnt)
    );

    // ---------------- DUT B / C ----------------
    logic       b_start    = 1'b0;
    logic       c_start    = 1'b0;
    logic       bc_abort   = 1'b0;
    logic       bc_s_valid = 1'b0;
    logic [7:0] bc_s_data  = 8'h00;
    logic       b_s_ready, b_pal_cfg, b_pal_shift, b_pal_en, b_busy, b_done, b_err;
    logic [4:0] b_bit_cnt;
    logic       c_s_ready, c_pal_cfg, c_pal_shift, c_pal_en, c_busy, c_done, c_err;
    logic [9:0] c_bit_cnt;

    pal_cfg_loader #(.CFG_BITS(20), .WORD_W(8), .APPLY_CYCLES(2), .TIMEOUT(16)) u_dut_b (
        .clk(clk), .res_n(res_n), .start(b_start), .abort(bc_abort),
        .s_data(bc_s_data), .s_valid(bc_s_valid), .s_ready(b_s_ready),
        .pal_cfg(b_pal_cfg), .pal_shift(b_pal_shift), .pal_en(b_pal_en),
        .busy(b_busy), .done(b_done), .err(b_err), .bit_cnt(b_bit_cnt)
    );

    pal_cfg_loader #(.CFG_BITS(736), .WORD_W(8), .APPLY_CYCLES(2), .TIMEOUT(16)) u_dut_c (
        .clk(clk), .res_n(res_n), .start(c_start), .abort(bc_abort),
        .s_data(bc_s_data), .s_valid(bc_s_valid), .s_ready(c_s_ready),
        .pal_cfg(c_pal_cfg), .pal_shift(c_pal_shift), .pal_en(c_pal_en),
        .busy(c_busy), .done(c_done), .err(c_err), .bit_cnt(c_bit_cnt)
    );

    // ---------------- reference data for A ----------------
    function automatic logic [7:0] word_a(input int i);
        return 8'((i * 37 + 90) ^ (i >> 3));
    endfunction

    function automatic logic exp_bit_a(input int n);
        logic [7:0] w;
        w = word_a(n / 8);
        return w[7 - (n % 8)];
    endfunction

    // ---------------- stream statistics for A ----------------
    int   sa_shift, sa_first, sa_last, sa_en, sa_en_first, sa_first_acc, sa_bad, sa_first_bad;
    bit   sa_err_seen, sa_finished, sa_aborted, sa_rst_done;
    logic r_en, r_busy, r_shift, r_ready, r_done;
    logic [9:0] r_cnt;

    // Drives one load into A. Stats land in sa_*; no comparisons here.
    task automatic stream_a(input int gap_after, input int gap_len, input int abort_bit,
                            input int start_bit, input bit rst_in_apply);
        int idx;
        int gap_left;
        bit abort_pending;
        idx = 0; gap_left = 0; abort_pending = 0;
        sa_shift = 0; sa_first = -1; sa_last = -1; sa_en = 0; sa_en_first = -1;
        sa_first_acc = -1; sa_bad = 0; sa_first_bad = -1;
        sa_err_seen = 0; sa_finished = 0; sa_aborted = 0; sa_rst_done = 0;
        a_start = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            a_start = 1'b0;
            if (abort_pending) begin
                a_abort = 1'b0; sa_aborted = 1; sa_finished = 1;
                break;
            end
            if (a_pal_shift) begin
                if (a_pal_cfg !== exp_bit_a(sa_shift)) begin
                    if (sa_first_bad < 0) sa_first_bad = sa_shift;
                    sa_bad++;
                end
                if (sa_first < 0) sa_first = c;
                sa_last = c;
                sa_shift++;
            end
            if (a_pal_en) begin
                if (sa_en_first < 0) sa_en_first = c;
                sa_en++;
            end
            if (a_err) sa_err_seen = 1;
            if (a_done || a_err) begin
                sa_finished = 1; a_s_valid = 1'b0;
                break;
            end
            if (rst_in_apply && a_pal_en) begin
                #2 res_n = 1'b0;
                #1;
                r_en = a_pal_en; r_busy = a_busy; r_shift = a_pal_shift;
                r_ready = a_s_ready; r_done = a_done; r_cnt = a_bit_cnt;
                #1 res_n = 1'b1;
                sa_rst_done = 1; sa_finished = 1; a_s_valid = 1'b0;
                break;
            end
            if (abort_bit >= 0 && int'(a_bit_cnt) == abort_bit) begin
                a_abort = 1'b1; a_s_valid = 1'b0; abort_pending = 1;
                continue;
            end
            if (start_bit >= 0 && int'(a_bit_cnt) == start_bit && a_pal_shift) a_start = 1'b1;
            if (gap_left > 0) begin
                a_s_valid = 1'b0;
                if (a_s_ready) gap_left--;
            end else if (idx < NW_A) begin
                a_s_valid = 1'b1;
                a_s_data  = word_a(idx);
                if (a_s_ready) begin
                    if (sa_first_acc < 0) sa_first_acc = c;
                    idx++;
                    if (idx == gap_after) gap_left = gap_len;
                end
            end else begin
                a_s_valid = 1'b0;
            end
        end
        a_s_valid = 1'b0;
        a_abort   = 1'b0;
    endtask

    // ---------------- stream statistics for B / C ----------------
    logic [7:0]  wb [4] = '{8'hA5, 8'h3C, 8'hF0, 8'h77};
    int          bs_shift, bs_first, bs_last, bs_en, bs_err_iter, bs_acc;
    bit          bs_finished;
    logic [31:0] bs_vec;

    task automatic stream_b(input int nwords, input bit tgt_c);
        int idx;
        logic rdy, sh, cf, en, dn, er;
        idx = 0;
        bs_shift = 0; bs_first = -1; bs_last = -1; bs_en = 0; bs_err_iter = -1;
        bs_acc = 0; bs_finished = 0; bs_vec = '0;
        if (tgt_c) c_start = 1'b1; else b_start = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            b_start = 1'b0; c_start = 1'b0;
            rdy = tgt_c ? c_s_ready   : b_s_ready;
            sh  = tgt_c ? c_pal_shift : b_pal_shift;
            cf  = tgt_c ? c_pal_cfg   : b_pal_cfg;
            en  = tgt_c ? c_pal_en    : b_pal_en;
            dn  = tgt_c ? c_done      : b_done;
            er  = tgt_c ? c_err       : b_err;
            if (sh) begin
                bs_vec = {bs_vec[30:0], cf};
                if (bs_first < 0) bs_first = c;
                bs_last = c;
                bs_shift++;
            end
            if (en) bs_en++;
            if (er && bs_err_iter < 0) bs_err_iter = c;
            if (dn || er) begin
                bs_finished = 1;
                break;
            end
            if (idx < nwords) begin
                bc_s_valid = 1'b1;
                bc_s_data  = wb[idx];
                if (rdy) begin
                    idx++;
                    bs_acc++;
                end
            end else begin
                bc_s_valid = 1'b0;
            end
        end
        bc_s_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        res_n = 1'b0;
        #1;
        n_checks++;
        if ({a_busy, a_done, a_err, a_s_ready, a_pal_shift, a_pal_en, a_pal_cfg} !== 7'b0) begin
            n_errors++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {a_busy, a_done, a_err, a_s_ready, a_pal_shift, a_pal_en, a_pal_cfg});
        end
        n_checks++;
        if (a_bit_cnt !== 10'd0) begin
            n_errors++;
            $display("FAIL reset_bit_cnt: got %0d expected 0", a_bit_cnt);
        end
        repeat (2) @(negedge clk);
        res_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({a_busy, b_busy, c_busy, a_s_ready} !== 4'b0) begin
            n_errors++;
            $display("FAIL idle_after_reset: got %b expected 0000", {a_busy, b_busy, c_busy, a_s_ready});
        end
        $display("test_reset: done");
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        stream_a(-1, 0, -1, -1, 1'b0);
        n_checks++;
        if (sa_finished !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_finished: got %0d expected 1", sa_finished);
        end
        n_checks++;
        if (sa_shift !== CFG_A) begin
            n_errors++;
            $display("FAIL b2b_shift_count: got %0d expected %0d", sa_shift, CFG_A);
        end
        n_checks++;
        if (sa_last - sa_first + 1 !== CFG_A) begin
            n_errors++;
            $display("FAIL b2b_contiguous: got span %0d expected %0d", sa_last - sa_first + 1, CFG_A);
        end
        n_checks++;
        if (sa_first !== sa_first_acc + 1) begin
            n_errors++;
            $display("FAIL b2b_latency: got first shift %0d expected %0d", sa_first, sa_first_acc + 1);
        end
        n_checks++;
        if (sa_bad !== 0) begin
            n_errors++;
            $display("FAIL b2b_bits: got %0d bad bits (first %0d) expected 0", sa_bad, sa_first_bad);
        end
        n_checks++;
        if (sa_en !== 2 || sa_en_first !== sa_last + 1) begin
            n_errors++;
            $display("FAIL b2b_apply: got %0d cycles from %0d expected 2 from %0d",
                     sa_en, sa_en_first, sa_last + 1);
        end
        n_checks++;
        if ({a_done, a_err, a_busy, a_pal_shift, a_s_ready} !== 5'b10000 || a_bit_cnt !== 10'd736) begin
            n_errors++;
            $display("FAIL b2b_end_state: got flags %b cnt %0d expected 10000 cnt 736",
                     {a_done, a_err, a_busy, a_pal_shift, a_s_ready}, a_bit_cnt);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (a_done !== 1'b1 || a_pal_en !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_done_sticky: got done %b en %b expected 1 0", a_done, a_pal_en);
        end
        $display("test_back_to_back: shifts %0d apply %0d", sa_shift, sa_en);
    endtask

    task automatic test_stall;
        @(negedge clk);
        stream_a(10, 5, -1, -1, 1'b0);
        n_checks++;
        if (sa_shift !== CFG_A || sa_bad !== 0) begin
            n_errors++;
            $display("FAIL stall_bits: got %0d shifts %0d bad expected %0d shifts 0 bad",
                     sa_shift, sa_bad, CFG_A);
        end
        n_checks++;
        if (sa_last - sa_first + 1 !== CFG_A + 5) begin
            n_errors++;
            $display("FAIL stall_gap: got span %0d expected %0d", sa_last - sa_first + 1, CFG_A + 5);
        end
        n_checks++;
        if (sa_err_seen !== 1'b0 || a_done !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_result: got err %0d done %b expected 0 1", sa_err_seen, a_done);
        end
        $display("test_stall: span %0d", sa_last - sa_first + 1);
    endtask

    task automatic test_abort;
        @(negedge clk);
        stream_a(-1, 0, 300, -1, 1'b0);
        n_checks++;
        if (sa_aborted !== 1'b1 || sa_shift !== 301) begin
            n_errors++;
            $display("FAIL abort_reached: got aborted %0d shifts %0d expected 1 301", sa_aborted, sa_shift);
        end
        n_checks++;
        if ({a_busy, a_done, a_err, a_pal_shift, a_pal_en, a_s_ready} !== 6'b0 || a_bit_cnt !== 10'd0) begin
            n_errors++;
            $display("FAIL abort_idle: got flags %b cnt %0d expected 000000 cnt 0",
                     {a_busy, a_done, a_err, a_pal_shift, a_pal_en, a_s_ready}, a_bit_cnt);
        end
        // abort and start together: abort wins
        a_start = 1'b1; a_abort = 1'b1;
        @(negedge clk);
        a_start = 1'b0; a_abort = 1'b0;
        n_checks++;
        if (a_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_beats_start: got busy %b expected 0", a_busy);
        end
        stream_a(-1, 0, -1, -1, 1'b0);
        n_checks++;
        if (a_done !== 1'b1 || sa_shift !== CFG_A || sa_bad !== 0) begin
            n_errors++;
            $display("FAIL abort_reload: got done %b shifts %0d bad %0d expected 1 %0d 0",
                     a_done, sa_shift, sa_bad, CFG_A);
        end
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        n_checks++;
        if (a_done !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_clears_done: got %b expected 0", a_done);
        end
        $display("test_abort: done");
    endtask

    task automatic test_partial_word;
        @(negedge clk);
        stream_b(4, 1'b0);
        n_checks++;
        if (bs_finished !== 1'b1 || b_done !== 1'b1) begin
            n_errors++;
            $display("FAIL partial_done: got fin %0d done %b expected 1 1", bs_finished, b_done);
        end
        n_checks++;
        if (bs_shift !== 20 || bs_last - bs_first + 1 !== 20) begin
            n_errors++;
            $display("FAIL partial_count: got %0d shifts span %0d expected 20 20",
                     bs_shift, bs_last - bs_first + 1);
        end
        n_checks++;
        if (bs_vec[19:0] !== 20'hA53CF) begin
            n_errors++;
            $display("FAIL partial_bits: got %h expected a53cf", bs_vec[19:0]);
        end
        n_checks++;
        if (bs_acc !== 3 || bs_en !== 2 || b_bit_cnt !== 5'd20) begin
            n_errors++;
            $display("FAIL partial_words: got acc %0d en %0d cnt %0d expected 3 2 20",
                     bs_acc, bs_en, b_bit_cnt);
        end
        $display("test_partial_word: bits %h", bs_vec[19:0]);
    endtask

    task automatic test_timeout;
        @(negedge clk);
        stream_b(3, 1'b1);
        n_checks++;
        if (bs_err_iter !== bs_last + 17) begin
            n_errors++;
            $display("FAIL timeout_timing: got err at %0d expected %0d", bs_err_iter, bs_last + 17);
        end
        n_checks++;
        if ({c_err, c_busy, c_done, c_pal_en, c_s_ready} !== 5'b10000 || bs_en !== 0) begin
            n_errors++;
            $display("FAIL timeout_flags: got %b en cycles %0d expected 10000 0",
                     {c_err, c_busy, c_done, c_pal_en, c_s_ready}, bs_en);
        end
        n_checks++;
        if (bs_shift !== 24 || bs_vec[23:0] !== 24'hA53CF0 || c_bit_cnt !== 10'd24) begin
            n_errors++;
            $display("FAIL timeout_bits: got %0d shifts %h cnt %0d expected 24 a53cf0 24",
                     bs_shift, bs_vec[23:0], c_bit_cnt);
        end
        $display("test_timeout: err after %0d idle cycles", bs_err_iter - bs_last - 1);
    endtask

    task automatic test_start_ignored_reset;
        @(negedge clk);
        stream_a(-1, 0, -1, 400, 1'b1);
        n_checks++;
        if (sa_rst_done !== 1'b1 || sa_shift !== CFG_A || sa_bad !== 0 || sa_en_first !== sa_last + 1) begin
            n_errors++;
            $display("FAIL start_ignored: got rst %0d shifts %0d bad %0d en_at %0d expected 1 %0d 0 %0d",
                     sa_rst_done, sa_shift, sa_bad, sa_en_first, CFG_A, sa_last + 1);
        end
        n_checks++;
        if ({r_en, r_busy, r_shift, r_ready, r_done} !== 5'b0 || r_cnt !== 10'd0) begin
            n_errors++;
            $display("FAIL async_reset: got flags %b cnt %0d expected 00000 cnt 0",
                     {r_en, r_busy, r_shift, r_ready, r_done}, r_cnt);
        end
        @(negedge clk);
        n_checks++;
        if ({a_busy, a_pal_en, a_done} !== 3'b0) begin
            n_errors++;
            $display("FAIL post_reset_idle: got %b expected 000", {a_busy, a_pal_en, a_done});
        end
        $display("test_start_ignored_reset: done");
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset;
        test_back_to_back;
        test_stall;
        test_abort;
        test_partial_word;
        test_timeout;
        test_start_ignored_reset;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
